// File: rtl/counter8_seq_pkg.sv
// Shared opcodes, sequencer state type and timer width for the counter8
// command sequencer.
package counter8_seq_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_CLR   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_UP    = 3'd3;
    localparam logic [2:0] OP_DOWN  = 3'd4;
    localparam logic [2:0] OP_PAUSE = 3'd5;

    localparam int unsigned TMR_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_RUN,
        S_STOP,
        S_PAUSEW,
        S_FIN
    } state_t;

endpackage

// File: rtl/counter8_seq_timer.sv
// Loadable down-counter with zero flag, shared between the PAUSE length
// and the RUN timeout.
module seq_timer
    import counter8_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;

    // Saturates at zero so a late decrement cannot wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TMR_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter8_seq.sv
// Command sequencer in front of counter8: turns one accepted command into
// counter8 strobes, watches CNT_Q, and reports DONE or ERR.
module counter8_seq
    import counter8_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 260,
    parameter logic        MODE_VAL = 1'b1
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [2:0] CMD_OP,
    input  logic [7:0] CMD_ARG,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    input  logic [7:0] CNT_Q,
    output logic       CLR,
    output logic       LOAD,
    output logic       HOLD,
    output logic       INC_START,
    output logic       INC_END,
    output logic       DEC_START,
    output logic       DEC_END,
    output logic [7:0] DIN,
    output logic       MODE_SEL
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       arg_q, arg_d;
    logic             to_q, to_d;
    logic [7:0]       din_d;
    logic             clr_d, load_d, hold_d, done_d, err_d;
    logic             inc_s_d, inc_e_d, dec_s_d, dec_e_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic [7:0]       last_val;

    seq_timer u_timer (
        .clk      (CLK),
        .rst_n    (RESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign CMD_READY = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign MODE_SEL  = MODE_VAL;

    // The end strobe goes out on the edge that steps the counter onto the
    // target, so compare against the value one step short of it.
    assign last_val = (op_q == OP_UP) ? (arg_q - 8'd1) : (arg_q + 8'd1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arg_d    = arg_q;
        to_d     = to_q;
        din_d    = DIN;
        clr_d    = 1'b0;
        load_d   = 1'b0;
        hold_d   = 1'b0;
        inc_s_d  = 1'b0;
        inc_e_d  = 1'b0;
        dec_s_d  = 1'b0;
        dec_e_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    op_d  = CMD_OP;
                    arg_d = CMD_ARG;
                    to_d  = 1'b0;
                    case (CMD_OP)
                        OP_NOP: begin
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end
                        OP_CLR: begin
                            clr_d   = 1'b1;
                            state_d = S_STROBE;
                        end
                        OP_LOAD: begin
                            load_d  = 1'b1;
                            din_d   = CMD_ARG;
                            state_d = S_STROBE;
                        end
                        OP_UP, OP_DOWN, OP_PAUSE: state_d = S_STROBE;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_FIN;
                        end
                    endcase
                end
            end
            S_STROBE: begin
                case (op_q)
                    OP_UP, OP_DOWN: begin
                        if (CNT_Q == arg_q) begin
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            inc_s_d  = (op_q == OP_UP);
                            dec_s_d  = (op_q == OP_DOWN);
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(TIMEOUT - 1);
                            state_d  = S_RUN;
                        end
                    end
                    OP_PAUSE: begin
                        if (arg_q == 8'd0) begin
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            hold_d   = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = {1'b0, arg_q - 8'd1};
                            state_d  = S_PAUSEW;
                        end
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                endcase
            end
            S_RUN: begin
                if ((CNT_Q == last_val) || tmr_zero) begin
                    inc_e_d = (op_q == OP_UP);
                    dec_e_d = (op_q == OP_DOWN);
                    to_d    = (CNT_Q != last_val);
                    state_d = S_STOP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            S_STOP: begin
                err_d   = to_q;
                done_d  = !to_q;
                state_d = S_FIN;
            end
            S_PAUSEW: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    hold_d  = 1'b1;
                    tmr_dec = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            arg_q     <= '0;
            to_q      <= 1'b0;
            DIN       <= '0;
            CLR       <= 1'b0;
            LOAD      <= 1'b0;
            HOLD      <= 1'b0;
            INC_START <= 1'b0;
            INC_END   <= 1'b0;
            DEC_START <= 1'b0;
            DEC_END   <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            to_q      <= to_d;
            DIN       <= din_d;
            CLR       <= clr_d;
            LOAD      <= load_d;
            HOLD      <= hold_d;
            INC_START <= inc_s_d;
            INC_END   <= inc_e_d;
            DEC_START <= dec_s_d;
            DEC_END   <= dec_e_d;
            DONE      <= done_d;
            ERR       <= err_d;
        end
    end

endmodule

// File: tb/tb_counter8_seq.sv
// Bench for counter8_seq: a behavioural counter8 closes the CNT_Q loop and
// each command's strobes, pulses and step counts are checked against rules.
module tb_counter8_seq;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [2:0] CMD_OP = '0;
    logic [7:0] CMD_ARG = '0;
    logic       BUSY, DONE, ERR;
    logic [7:0] CNT_Q;
    logic       CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END;
    logic [7:0] DIN;
    logic       MODE_SEL;

    int n_assert = 0;
    int n_fail   = 0;

    counter8_seq #(.TIMEOUT(260), .MODE_VAL(1'b1)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_ARG   (CMD_ARG),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .CNT_Q     (CNT_Q),
        .CLR       (CLR),
        .LOAD      (LOAD),
        .HOLD      (HOLD),
        .INC_START (INC_START),
        .INC_END   (INC_END),
        .DEC_START (DEC_START),
        .DEC_END   (DEC_END),
        .DIN       (DIN),
        .MODE_SEL  (MODE_SEL)
    );

    always #5 CLK = ~CLK;

    // Behavioural counter8; 'stuck' models a counter that never steps.
    logic [7:0] cnt = '0;
    logic       run_up = 1'b0, run_dn = 1'b0, stuck = 1'b0;
    int         steps = 0;
    assign CNT_Q = cnt;

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt    <= '0;
            run_up <= 1'b0;
            run_dn <= 1'b0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (LOAD) begin
            cnt <= DIN;
        end else if (!HOLD) begin
            run_up <= INC_END ? 1'b0 : (run_up | INC_START);
            run_dn <= DEC_END ? 1'b0 : (run_dn | DEC_START);
            if ((INC_START || run_up) && !INC_END && !stuck) begin
                cnt   <= cnt + 8'd1;
                steps <= steps + 1;
            end else if ((DEC_START || run_dn) && !DEC_END && !stuck) begin
                cnt   <= cnt - 8'd1;
                steps <= steps + 1;
            end
        end
    end

    // Per-command observations, filled in by run_cmd.
    int         cyc, n_done, n_err, n_clr, n_load, n_hold, n_st, n_en, n_multi, n_both;
    int         done_at, err_at, st_at, en_at, hold_first, hold_last, n_step, n_hold_chg;
    logic [7:0] din_at_load, en_cnt, start_cnt;
    logic       hung;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] arg, input int budget);
        int steps0;
        int ns;
        @(negedge CLK);
        CMD_OP    = op;
        CMD_ARG   = arg;
        CMD_VALID = 1'b1;
        start_cnt = cnt;
        steps0    = steps;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_OP    = 3'($urandom);
        CMD_ARG   = 8'($urandom);
        {n_done, n_err, n_clr, n_load, n_hold, n_st, n_en, n_multi, n_both} = '0;
        {done_at, err_at, st_at, en_at, hold_first, hold_last, n_hold_chg} = '0;
        din_at_load = '0;
        en_cnt      = '0;
        cyc         = 0;
        while (cyc < budget) begin
            @(negedge CLK);
            cyc++;
            ns = int'(CLR) + int'(LOAD) + int'(HOLD) + int'(INC_START) + int'(INC_END)
               + int'(DEC_START) + int'(DEC_END);
            if (ns > 1) n_multi++;
            if (DONE && ERR) n_both++;
            if (DONE) begin n_done++; done_at = cyc; end
            if (ERR)  begin n_err++;  err_at  = cyc; end
            if (CLR)  n_clr++;
            if (LOAD) begin n_load++; din_at_load = DIN; end
            if (HOLD) begin
                if (n_hold == 0) hold_first = cyc;
                hold_last = cyc;
                n_hold++;
                if (CNT_Q != start_cnt) n_hold_chg++;
            end
            if (INC_START || DEC_START) begin n_st++; st_at = cyc; end
            if (INC_END || DEC_END) begin n_en++; en_at = cyc; en_cnt = CNT_Q; end
            if (CMD_READY) break;
        end
        hung   = !CMD_READY;
        n_step = steps - steps0;
    endtask

    task automatic check_ok(input string tag);
        check({tag, "_hung"}, 32'(hung), 32'd0);
        check({tag, "_done"}, 32'(n_done), 32'd1);
        check({tag, "_err"}, 32'(n_err), 32'd0);
        check({tag, "_multi"}, 32'(n_multi + n_both), 32'd0);
    endtask

    task automatic check_count(input logic is_up, input logic [7:0] tgt);
        logic [7:0] exp_steps;
        exp_steps = is_up ? (tgt - start_cnt) : (start_cnt - tgt);
        check_ok("cnt");
        check("cnt_final", 32'(CNT_Q), 32'(tgt));
        check("cnt_steps", 32'(n_step), 32'(exp_steps));
        check("cnt_start_pulses", 32'(n_st), (exp_steps == 0) ? 32'd0 : 32'd1);
        check("cnt_end_pulses", 32'(n_en), (exp_steps == 0) ? 32'd0 : 32'd1);
        if (exp_steps != 0) begin
            check("cnt_end_value", 32'(en_cnt), 32'(tgt));
            check("cnt_end_offset", 32'(en_at - st_at), 32'(exp_steps));
        end
    endtask

    initial begin
        logic [7:0] a, t;
        logic       up;
        int         n_de;

        #3;
        check("reset_outs", {CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END,
                             DONE, ERR, BUSY, CMD_READY}, 32'b00000000001);
        check("reset_din", 32'(DIN), 32'h00);
        check("mode_sel", 32'(MODE_SEL), 32'd1);
        @(negedge CLK);
        RESETn = 1'b1;

        run_cmd(3'd1, 8'h00, 20);
        check_ok("clr");
        check("clr_pulses", 32'(n_clr), 32'd1);
        check("clr_ready_cycles", 32'(cyc), 32'd3);
        check("clr_cnt", 32'(CNT_Q), 32'h00);

        run_cmd(3'd2, 8'h0A, 20);
        check_ok("load");
        check("load_pulses", 32'(n_load), 32'd1);
        check("load_din", 32'(din_at_load), 32'h0A);
        check("load_ready_cycles", 32'(cyc), 32'd3);
        check("load_cnt", 32'(CNT_Q), 32'h0A);

        run_cmd(3'd3, 8'h0F, 300);
        check_count(1'b1, 8'h0F);
        check("din_held", 32'(DIN), 32'h0A);

        run_cmd(3'd2, 8'hFC, 20);
        run_cmd(3'd3, 8'h02, 300);
        check_count(1'b1, 8'h02);

        run_cmd(3'd4, 8'h02, 300);
        check_count(1'b0, 8'h02);
        check("down_eq_done_at", 32'(done_at), 32'd2);

        run_cmd(3'd5, 8'd4, 50);
        check_ok("pause4");
        check("pause4_hold", 32'(n_hold), 32'd4);
        check("pause4_contig", 32'(hold_last - hold_first + 1), 32'd4);
        check("pause4_cnt_moved", 32'(n_hold_chg), 32'd0);
        check("pause4_cnt", 32'(CNT_Q), 32'h02);

        run_cmd(3'd5, 8'd0, 50);
        check_ok("pause0");
        check("pause0_hold", 32'(n_hold), 32'd0);

        run_cmd(3'd3, 8'h03, 300);
        check_count(1'b1, 8'h03);

        run_cmd(3'd0, 8'h55, 20);
        check_ok("nop");
        check("nop_strobes", 32'(n_clr + n_load + n_hold + n_st + n_en), 32'd0);

        for (int k = 6; k < 8; k++) begin
            run_cmd(3'(k), 8'h11, 20);
            check("ill_hung", 32'(hung), 32'd0);
            check("ill_err", 32'(n_err), 32'd1);
            check("ill_done", 32'(n_done), 32'd0);
            check("ill_strobes", 32'(n_clr + n_load + n_hold + n_st + n_en), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            a  = 8'($urandom);
            t  = (i == 0) ? a : 8'($urandom);
            up = 1'($urandom);
            run_cmd(3'd2, a, 20);
            check("rnd_load_cnt", 32'(CNT_Q), 32'(a));
            run_cmd(up ? 3'd3 : 3'd4, t, 300);
            check_count(up, t);
        end

        run_cmd(3'd2, 8'h02, 20);
        stuck = 1'b1;
        run_cmd(3'd3, 8'h10, 400);
        stuck = 1'b0;
        check("to_hung", 32'(hung), 32'd0);
        check("to_end_pulses", 32'(n_en), 32'd1);
        check("to_end_offset", 32'(en_at - st_at), 32'd260);
        check("to_err", 32'(n_err), 32'd1);
        check("to_err_at", 32'(err_at - en_at), 32'd1);
        check("to_done", 32'(n_done), 32'd0);
        check("to_cnt", 32'(CNT_Q), 32'h02);

        run_cmd(3'd1, 8'h00, 20);
        @(negedge CLK);
        CMD_OP    = 3'd3;
        CMD_ARG   = 8'h80;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        repeat (20) @(negedge CLK);
        check("rst_mid_busy", {BUSY, INC_START, INC_END}, 32'b100);
        #2;
        RESETn = 1'b0;
        #1;
        check("rst_mid_outs", {CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END,
                               DONE, ERR, BUSY, CMD_READY}, 32'b00000000001);
        check("rst_mid_cnt", 32'(CNT_Q), 32'h00);
        @(negedge CLK);
        RESETn = 1'b1;
        n_de = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DONE || ERR || !CMD_READY || INC_START || INC_END) n_de++;
        end
        check("rst_mid_after", 32'(n_de), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/counter8_seq.md
Name: counter8_seq

Overview:
- Command sequencer in front of counter8.
- Accepts one high-level command at a time over a valid/ready handshake: clear, load, count-up-to-target, count-down-to-target, pause-N-cycles.
- Generates the single-cycle control strobes and DIN that counter8 needs, and monitors counter8 DOUT (fed back as CNT_Q).
- Signals completion with DONE, or failure with ERR.

Parameters:
- TIMEOUT, 260: maximum cycles spent in RUN before the run is aborted with ERR. Must be ≥ 257.
- MODE_VAL, 1'b1: constant value driven on MODE_SEL.

Ports:
- CLK  in  1  single system clock, rising edge.
- RESETn  in  1  asynchronous active-low reset; same net that resets counter8.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command; high only in IDLE.
- CMD_OP  in  3  0 NOP, 1 CLR, 2 LOAD, 3 UP, 4 DOWN, 5 PAUSE, 6/7 illegal.
- CMD_ARG  in  8  LOAD value / UP-DOWN target / PAUSE length in cycles.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse: command completed.
- ERR  out  1  one-cycle pulse: illegal op or timeout.
- CNT_Q  in  8  counter8 DOUT.
- CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END  out  1 each  counter8 controls.
- DIN  out  8  counter8 load data.
- MODE_SEL  out  1  tied to MODE_VAL.

Behaviour:
- Reset (async, RESETn=0):
  - State is IDLE.
  - All strobes, DONE, ERR and BUSY are 0; DIN is 8'h00; CMD_READY is 1.
  - Reset mid-command drops every strobe immediately. No command is resumed after reset.
- All outputs except CMD_READY/BUSY are registered. CMD_READY and BUSY decode from state only.
- Accept: the command is taken on the rising edge where CMD_VALID & CMD_READY; CMD_OP/CMD_ARG are latched on that edge. CMD_* are ignored while BUSY.
- counter8 contract:
  - CLR/LOAD act on the edge that samples them.
  - While running, the counter steps ±1 on every edge, starting with the edge that samples INC_START/DEC_START.
  - It does not step on the edge that samples INC_END/DEC_END, and it wraps mod 256.
- States: IDLE, STROBE, RUN, STOP, PAUSEW, FIN.
  - Accept edge -> STROBE, except NOP/illegal, which go straight to FIN.
- CLR: CLR=1 for the STROBE cycle -> FIN -> DONE=1 -> IDLE. Three cycles from accept to CMD_READY.
- LOAD: DIN<=ARG on the accept edge; DIN holds that value until the next LOAD. LOAD=1 for the STROBE cycle -> FIN -> DONE.
- UP (DOWN is symmetric: DEC_*, ARG+1):
  - If CNT_Q==ARG in the STROBE cycle: no strobes, go to FIN with DONE.
  - Otherwise INC_START=1 for one cycle, then RUN.
  - INC_END is set on the edge where CNT_Q==ARG-1 (mod 256), in the start cycle or in RUN. It is therefore high for exactly one cycle, the cycle in which CNT_Q first equals ARG.
  - Then FIN, DONE.
  - Required: final CNT_Q==ARG; step count = (ARG-start) mod 256 (down: (start-ARG) mod 256); wrap through 255/0 is legal.
- Timeout: a cycle counter runs from the start strobe. If it reaches TIMEOUT while still in RUN:
  - assert INC_END/DEC_END for one cycle;
  - then ERR=1 (no DONE) and return to IDLE.
- PAUSE:
  - ARG==0: DONE with no HOLD.
  - Otherwise HOLD=1 for exactly ARG consecutive cycles (PAUSEW), then FIN, DONE.
- NOP: DONE in FIN. Illegal op 6/7: ERR in FIN, no strobes.
- DONE and ERR are mutually exclusive. At most one counter8 strobe is high in any cycle, except the permitted INC_START+INC_END overlap; that overlap never happens because one-step runs end one cycle after start.

Decomposition:
- Package counter8_seq_pkg: opcode localparams (OP_NOP..OP_PAUSE), state encodings, timer width (9 bits).
- One sub-module, seq_timer: 9-bit loadable down-counter with zero flag, shared between PAUSE length and RUN timeout.

Test Plan:
- Reset, then CLR, then LOAD ARG=8'h0A -> CLR pulse 1 cycle; LOAD pulse with DIN=0x0A; CNT_Q=0x0A; two DONE pulses; CMD_READY back 3 cycles after each accept.
- CNT_Q=0x0A, UP ARG=0x0F -> INC_START 1 cycle; exactly 5 increments; INC_END high in the cycle CNT_Q=0x0F; final 0x0F; one DONE.
- CNT_Q=0xFC, UP ARG=0x02 -> 6 steps through 0xFF->0x00; final 0x02. Then DOWN ARG=0x02 -> no strobes, DONE 2 cycles after accept.
- PAUSE ARG=4 mid-sequence -> HOLD high exactly 4 cycles; CNT_Q unchanged; DONE. PAUSE ARG=0 -> no HOLD, DONE.
- Counter model stuck (never steps), UP ARG=0x10 -> after TIMEOUT=260 cycles INC_END 1 cycle, then ERR pulse, no DONE. Illegal op 7 -> ERR only.
- RESETn low during RUN of UP 0x00->0x80 -> all strobes 0 asynchronously; CMD_READY=1 after release; no DONE/ERR.
